// File: rtl/res_dnn_pkg.sv
// Shared types and constants for the residue accumulator sequencer.
// Holds the FSM state encoding, default datapath sizing and the
// helper that derives the width of the unreduced beat sum.
package res_dnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_N   = 12;
    localparam int DEF_MOD = 4093;

    // acc + a + b stays below 3 * 2**N, so two guard bits are enough.
    function automatic int sum_w(input int n);
        return n + 2;
    endfunction

endpackage

// File: rtl/res_acc_seq_if.sv
// Handshake bundle for res_acc_seq: frame start, operand input stream,
// result output stream and status flags. The master drives operands and
// accepts results; the slave is the sequencer itself.
interface res_acc_seq_if #(
    parameter int N = 12
);
    logic         start;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_res;
    logic         busy;
    logic         err;

    modport master (
        output start, in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_res, busy, err
    );

    modport slave (
        input  start, in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_res, busy, err
    );
endinterface

// File: rtl/res_acc_seq_mod_corr_sel.sv
// Combinational modulo correction for a sum known to be below 3*MOD.
// Produces the two threshold flags and the reduced residue, giving the
// 2*MOD subtraction priority so the result is always below MOD.
module mod_corr_sel #(
    parameter int N  = 12,
    parameter int SW = 14
) (
    input  logic [SW-1:0] s,
    input  logic [SW-1:0] mod_val,
    output logic          c2,
    output logic          c3,
    output logic [N-1:0]  res
);
    logic [SW-1:0] two_mod;

    assign two_mod = mod_val << 1;

    // Compare against both thresholds and pick the matching candidate.
    always_comb begin
        c2  = (s >= mod_val);
        c3  = (s >= two_mod);
        res = N'(s);
        if (c3) begin
            res = N'(s - two_mod);
        end else if (c2) begin
            res = N'(s - mod_val);
        end
    end
endmodule

// File: rtl/res_acc_seq.sv
// Residue accumulator sequencer: after a start pulse, accepts LEN operand
// pairs and folds each into acc = (acc + a + b) mod MOD, then offers the
// residue on a valid/ready output until it is taken.
// Optional feature macro: RANGE_CHK_EN (operand range check with sticky err).
module res_acc_seq
    import res_dnn_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int MOD   = DEF_MOD,
    parameter int LEN   = 16,
    parameter int CNT_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    res_acc_seq_if.slave  bus
);
    localparam int SW = sum_w(N);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_ACC  = ACC;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]       state;
    logic [N-1:0]     acc;
    logic [N-1:0]     res_q;
    logic [CNT_W-1:0] cnt;

    logic             beat;
    logic             last_beat;
    logic [N-1:0]     a_eff;
    logic [N-1:0]     b_eff;
    logic [SW-1:0]    s;
    logic [N-1:0]     acc_next;
    logic             c2;
    logic             c3;
    logic             unused_corr;

    assign beat      = (state == S_ACC) && bus.in_valid;
    assign last_beat = beat && (cnt == CNT_W'(LEN - 1));

`ifdef RANGE_CHK_EN
    localparam logic [N:0] MOD_CMP = (N + 1)'(MOD);

    logic a_bad;
    logic b_bad;
    logic range_hit;
    logic err_q;

    assign a_bad     = ({1'b0, bus.in_a} >= MOD_CMP);
    assign b_bad     = ({1'b0, bus.in_b} >= MOD_CMP);
    assign a_eff     = a_bad ? '0 : bus.in_a;
    assign b_eff     = b_bad ? '0 : bus.in_b;
    assign range_hit = beat && (a_bad || b_bad);

    // Sticky error: cleared by a new frame start, set by any bad accepted operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((state == S_IDLE) && bus.start) begin
            err_q <= 1'b0;
        end else if (range_hit) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign a_eff   = bus.in_a;
    assign b_eff   = bus.in_b;
    assign bus.err = 1'b0;
`endif

    assign s = SW'(acc) + SW'(a_eff) + SW'(b_eff);

    mod_corr_sel #(
        .N  (N),
        .SW (SW)
    ) u_corr (
        .s       (s),
        .mod_val (SW'(MOD)),
        .c2      (c2),
        .c3      (c3),
        .res     (acc_next)
    );

    // Threshold flags are only needed inside the selector; they are kept
    // on the instance so the block stays reusable elsewhere.
    assign unused_corr = c2 ^ c3;

    // Frame sequencing, accumulation and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
            res_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state <= S_ACC;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                S_ACC: begin
                    if (beat) begin
                        acc <= acc_next;
                        cnt <= cnt + CNT_W'(1);
                        if (last_beat) begin
                            state <= S_DONE;
                            res_q <= acc_next;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == S_ACC);
    assign bus.out_valid = (state == S_DONE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.out_res   = res_q;
endmodule

// File: tb/tb_res_acc_seq.sv
// Self-checking bench for res_acc_seq with N=12, MOD=4093.
// Two instances: LEN=4 (sel 0) and LEN=2 (sel 1). A per-cycle vector
// table covers the plain, bubbled, correction-path and range-check frames;
// hand-written sequences cover the DONE stall and the mid-frame reset.
// Optional feature macro: RANGE_CHK_EN (changes expected err/out_res).
module tb_res_acc_seq;
    localparam int N   = 12;
    localparam int MOD = 4093;

`ifdef RANGE_CHK_EN
    localparam bit E6 = 1'b1;
    localparam bit R6 = 1'b1;
`else
    localparam bit E6 = 1'b0;
    localparam bit R6 = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    res_acc_seq_if #(.N(N)) bus4 ();
    res_acc_seq_if #(.N(N)) bus2 ();

    res_acc_seq #(.N(N), .MOD(MOD), .LEN(4), .CNT_W(3)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    res_acc_seq #(.N(N), .MOD(MOD), .LEN(2), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit    sel;
        bit    st;
        bit    v;
        int    a;
        int    b;
        bit    ordy;
        bit    ir;
        bit    ov;
        int    res;
        bit    chk;
        bit    bsy;
        bit    er;
        string name;
    } row_t;

    row_t rows[$];

    function automatic row_t mk(input string name, input bit sel, input bit st,
                                input bit v, input int a, input int b, input bit ordy,
                                input bit ir, input bit ov, input int res, input bit chk,
                                input bit bsy, input bit er);
        row_t r;
        r.name = name; r.sel = sel; r.st = st; r.v = v; r.a = a; r.b = b;
        r.ordy = ordy; r.ir = ir; r.ov = ov; r.res = res; r.chk = chk;
        r.bsy = bsy; r.er = er;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit sel, input bit st, input bit v,
                                 input int a, input int b, input bit ordy);
        bus4.start = 1'b0; bus4.in_valid = 1'b0; bus4.in_a = '0; bus4.in_b = '0; bus4.out_ready = 1'b0;
        bus2.start = 1'b0; bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0; bus2.out_ready = 1'b0;
        if (sel == 1'b0) begin
            bus4.start = st; bus4.in_valid = v; bus4.in_a = N'(a); bus4.in_b = N'(b); bus4.out_ready = ordy;
        end else begin
            bus2.start = st; bus2.in_valid = v; bus2.in_a = N'(a); bus2.in_b = N'(b); bus2.out_ready = ordy;
        end
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("[TB] FAIL %s step %0d: got %0d want %0d", name, idx, got, want);
        end
    endtask

    task automatic checkAll(input string name, input int idx, input bit sel,
                            input bit ir, input bit ov, input int res, input bit chk,
                            input bit bsy, input bit er);
        if (sel == 1'b0) begin
            checkOutput({name, ".in_ready"},  idx, int'(bus4.in_ready),  int'(ir));
            checkOutput({name, ".out_valid"}, idx, int'(bus4.out_valid), int'(ov));
            checkOutput({name, ".busy"},      idx, int'(bus4.busy),      int'(bsy));
            checkOutput({name, ".err"},       idx, int'(bus4.err),       int'(er));
            if (chk) checkOutput({name, ".out_res"}, idx, int'(bus4.out_res), res);
        end else begin
            checkOutput({name, ".in_ready"},  idx, int'(bus2.in_ready),  int'(ir));
            checkOutput({name, ".out_valid"}, idx, int'(bus2.out_valid), int'(ov));
            checkOutput({name, ".busy"},      idx, int'(bus2.busy),      int'(bsy));
            checkOutput({name, ".err"},       idx, int'(bus2.err),       int'(er));
            if (chk) checkOutput({name, ".out_res"}, idx, int'(bus2.out_res), res);
        end
    endtask

    initial begin
        // Test 1: LEN=4 plain frame, 1+2+...+8 = 36.
        rows.push_back(mk("t1", 0, 1, 0, 0,    0,    0, 0, 0, 0,    0, 0, 0));
        rows.push_back(mk("t1", 0, 0, 1, 1,    2,    0, 1, 0, 0,    0, 1, 0));
        rows.push_back(mk("t1", 0, 0, 1, 3,    4,    0, 1, 0, 0,    0, 1, 0));
        rows.push_back(mk("t1", 0, 0, 1, 5,    6,    0, 1, 0, 0,    0, 1, 0));
        rows.push_back(mk("t1", 0, 0, 1, 7,    8,    0, 1, 0, 0,    0, 1, 0));
        rows.push_back(mk("t1", 0, 0, 0, 0,    0,    0, 0, 1, 36,   1, 1, 0));
        rows.push_back(mk("t1", 0, 0, 0, 0,    0,    1, 0, 1, 36,   1, 1, 0));
        rows.push_back(mk("t1", 0, 0, 0, 0,    0,    0, 0, 0, 0,    0, 0, 0));
        // Test 3: bubbles every other cycle, same result.
        rows.push_back(mk("t3", 0, 1, 0, 0,    0,    0, 0, 0, 0,    0, 0, 0));
        rows.push_back(mk("t3", 0, 0, 1, 1,    2,    0, 1, 0, 0,    0, 1, 0));
        rows.push_back(mk("t3", 0, 0, 0, 9,    9,    0, 1, 0, 0,    0, 1, 0));
        rows.push_back(mk("t3", 0, 0, 1, 3,    4,    0, 1, 0, 0,    0, 1, 0));
        rows.push_back(mk("t3", 0, 0, 0, 9,    9,    0, 1, 0, 0,    0, 1, 0));
        rows.push_back(mk("t3", 0, 0, 1, 5,    6,    0, 1, 0, 0,    0, 1, 0));
        rows.push_back(mk("t3", 0, 0, 0, 9,    9,    0, 1, 0, 0,    0, 1, 0));
        rows.push_back(mk("t3", 0, 0, 1, 7,    8,    0, 1, 0, 0,    0, 1, 0));
        rows.push_back(mk("t3", 0, 0, 0, 0,    0,    1, 0, 1, 36,   1, 1, 0));
        rows.push_back(mk("t3", 0, 0, 0, 0,    0,    0, 0, 0, 0,    0, 0, 0));
        // Test 2: LEN=2, 8184 -> 4091 (one MOD off), 12275 -> 4089 (two MOD off).
        rows.push_back(mk("t2", 1, 1, 0, 0,    0,    0, 0, 0, 0,    0, 0, 0));
        rows.push_back(mk("t2", 1, 0, 1, 4092, 4092, 0, 1, 0, 0,    0, 1, 0));
        rows.push_back(mk("t2", 1, 0, 1, 4092, 4092, 0, 1, 0, 0,    0, 1, 0));
        rows.push_back(mk("t2", 1, 0, 0, 0,    0,    1, 0, 1, 4089, 1, 1, 0));
        rows.push_back(mk("t2", 1, 0, 0, 0,    0,    0, 0, 0, 0,    0, 0, 0));
        // Test 6: out-of-range operand; err sticky until the next start.
        rows.push_back(mk("t6", 1, 1, 0, 0,    0,    0, 0, 0, 0,    0, 0, 0));
        rows.push_back(mk("t6", 1, 0, 1, 4093, 5,    0, 1, 0, 0,    0, 1, 0));
        rows.push_back(mk("t6", 1, 0, 1, 1,    1,    0, 1, 0, 0,    0, 1, E6));
        rows.push_back(mk("t6", 1, 0, 0, 0,    0,    0, 0, 1, 7,    R6, 1, E6));
        rows.push_back(mk("t6", 1, 0, 0, 0,    0,    1, 0, 1, 7,    R6, 1, E6));
        rows.push_back(mk("t6", 1, 1, 0, 0,    0,    0, 0, 0, 0,    0, 0, E6));
        rows.push_back(mk("t6", 1, 0, 0, 0,    0,    0, 1, 0, 0,    0, 1, 0));

        // Reset state of both instances.
        applyStimulus(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        step();
        checkAll("reset4", 0, 0, 0, 0, 0, 1, 0, 0);
        checkAll("reset2", 0, 1, 0, 0, 0, 1, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < rows.size(); i++) begin
            applyStimulus(rows[i].sel, rows[i].st, rows[i].v, rows[i].a, rows[i].b, rows[i].ordy);
            checkAll(rows[i].name, i, rows[i].sel, rows[i].ir, rows[i].ov, rows[i].res,
                     rows[i].chk, rows[i].bsy, rows[i].er);
            step();
        end

        // Test 4: result held through a stalled DONE with start pulsed.
        applyStimulus(0, 1, 0, 0, 0, 0);
        step();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 1, 2 * k + 1, 2 * k + 2, 0);
            step();
        end
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 1, 0, 0, 0, 0);
            checkAll("t4_hold", k, 0, 0, 1, 36, 1, 1, 0);
            step();
        end
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkAll("t4_hs", 0, 0, 0, 1, 36, 1, 1, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("t4_idle", 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        checkAll("t4_idle", 1, 0, 0, 0, 0, 0, 0, 0);

        // Test 5: reset after two beats wins over a pending beat.
        applyStimulus(0, 1, 0, 0, 0, 0);
        step();
        applyStimulus(0, 0, 1, 9, 9, 0);
        step();
        step();
        checkAll("t5_mid", 0, 0, 1, 0, 0, 0, 1, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("t5_rst4", 0, 0, 0, 0, 0, 1, 0, 0);
        checkAll("t5_rst2", 0, 1, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        step();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 1, 1, 1, 0);
            checkAll("t5_beat", k, 0, 1, 0, 0, 0, 1, 0);
            step();
        end
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkAll("t5_done", 0, 0, 0, 1, 8, 1, 1, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("t5_idle", 0, 0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
